// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL lock sequencer.
// Contents:
//   state_e               sequencer states
//   DEF_*                 default values for the sequencer parameters
package pll_seq_pkg;

   localparam int unsigned DEF_RST_PULSE_CYC    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
   localparam int unsigned DEF_MAX_RETRY        = 7;

   localparam int unsigned LOSS_CNT_W  = 8;
   localparam int unsigned RETRY_OUT_W = 3;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication onto refclk.
// Ports:
//   clk       sampling clock
//   rst_n     async active-low reset, clears both flops to 0
//   async_in  asynchronous input
//   sync_out  synchronized output (two clock latency)
module pll_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the core reset; retries on lock timeout and parks in FAULT
// after too many failures.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to build the saturating
// lock-loss counter; otherwise lock_loss_cnt is tied to 0.
// Ports:
//   refclk         PLL reference clock, all logic on its rising edge
//   rst_n          async active-low reset
//   pll_locked     PLL lock indication (asynchronous)
//   soft_reset     synchronous request to restart the sequence
//   pll_rst        active-high PLL reset
//   core_reset     active-high reset for logic on the PLL output clocks
//   fault          high while in FAULT
//   retry_cnt      failed attempts in the current sequence
//   lock_loss_cnt  saturating count of lock losses seen in RUN
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   soft_reset,
   output logic                   pll_rst,
   output logic                   core_reset,
   output logic                   fault,
   output logic [RETRY_OUT_W-1:0] retry_cnt,
   output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

   localparam int unsigned PULSE_W = $clog2(RST_PULSE_CYC + 1);
   localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
   localparam int unsigned STAB_W  = $clog2(LOCK_STABLE_CYC + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   state_e             state;
   logic               lk;
   logic [PULSE_W-1:0] pulse_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [STAB_W-1:0]  stab_cnt;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_inc_c;

   pll_lock_sync u_sync (
      .clk      (refclk),
      .rst_n    (rst_n),
      .async_in (pll_locked),
      .sync_out (lk)
   );

   // retry_q never reaches its width limit: the attempt that hits MAX_RETRY parks in FAULT
   assign retry_inc_c = retry_q + RETRY_W'(1);
   assign retry_cnt   = RETRY_OUT_W'(retry_q);

   // Sequencer; outputs are registered together with the state they belong to
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PLL_RST;
         pulse_cnt  <= '0;
         tmo_cnt    <= '0;
         stab_cnt   <= '0;
         retry_q    <= '0;
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         fault      <= 1'b0;
      end else if (soft_reset) begin
         state      <= PLL_RST;
         pulse_cnt  <= '0;
         retry_q    <= '0;
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         fault      <= 1'b0;
      end else begin
         case (state)
            PLL_RST: begin
               if (pulse_cnt == PULSE_W'(RST_PULSE_CYC - 1)) begin
                  state   <= WAIT_LOCK;
                  tmo_cnt <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  pulse_cnt <= pulse_cnt + PULSE_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (lk) begin
                  state    <= STABLE;
                  stab_cnt <= '0;
               end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1)) begin
                  retry_q   <= retry_inc_c;
                  pulse_cnt <= '0;
                  pll_rst   <= 1'b1;
                  if (32'(retry_inc_c) < MAX_RETRY) begin
                     state <= PLL_RST;
                  end else begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            STABLE: begin
               if (!lk) begin
                  state   <= WAIT_LOCK;
                  tmo_cnt <= '0;
               end else if (stab_cnt == STAB_W'(LOCK_STABLE_CYC - 1)) begin
                  state      <= RUN;
                  retry_q    <= '0;
                  core_reset <= 1'b0;
               end else begin
                  stab_cnt <= stab_cnt + STAB_W'(1);
               end
            end
            RUN: begin
               if (!lk) begin
                  state      <= PLL_RST;
                  pulse_cnt  <= '0;
                  pll_rst    <= 1'b1;
                  core_reset <= 1'b1;
               end
            end
            FAULT: begin
            end
            default: begin
               state      <= PLL_RST;
               pulse_cnt  <= '0;
               pll_rst    <= 1'b1;
               core_reset <= 1'b1;
               fault      <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic [LOSS_CNT_W-1:0] loss_q;

   // Lock loss in RUN; a same-cycle soft_reset wins and is not counted
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
      end else if (!soft_reset && (state == RUN) && !lk && (loss_q != '1)) begin
         loss_q <= loss_q + LOSS_CNT_W'(1);
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

   localparam int RP = 16;
   localparam int TO = 200;
   localparam int ST = 64;
   localparam int MR = 7;

   localparam int P_RST   = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAULT = 4;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_reset;
   logic       pll_rst;
   logic       core_reset;
   logic       fault;
   logic [2:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: phase, cycles spent in phase, counters, lock input history
   int m_phase;
   int m_t;
   int m_retry;
   int m_loss;
   bit pl_hist[$];

   pll_lock_sequencer #(
      .RST_PULSE_CYC    (RP),
      .LOCK_TIMEOUT_CYC (TO),
      .LOCK_STABLE_CYC  (ST),
      .MAX_RETRY        (MR)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .soft_reset    (soft_reset),
      .pll_rst       (pll_rst),
      .core_reset    (core_reset),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #10 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_phase = P_RST;
      m_t     = 0;
      m_retry = 0;
      m_loss  = 0;
      pl_hist.delete();
   endfunction

   // one rising edge of refclk; lock seen by the sequencer is the input from two edges earlier
   function automatic void model_edge(input bit pl, input bit sr);
      bit lk;
      lk = (pl_hist.size() >= 2) ? pl_hist[pl_hist.size() - 2] : 1'b0;
      pl_hist.push_back(pl);
      if (pl_hist.size() > 4) void'(pl_hist.pop_front());
      if (sr) begin
         m_phase = P_RST;
         m_t     = 0;
         m_retry = 0;
         return;
      end
      case (m_phase)
         P_RST: begin
            m_t++;
            if (m_t == RP) begin m_phase = P_WAIT; m_t = 0; end
         end
         P_WAIT: begin
            if (lk) begin
               m_phase = P_STAB; m_t = 0;
            end else begin
               m_t++;
               if (m_t == TO) begin
                  m_retry++;
                  m_phase = (m_retry < MR) ? P_RST : P_FAULT;
                  m_t = 0;
               end
            end
         end
         P_STAB: begin
            if (!lk) begin
               m_phase = P_WAIT; m_t = 0;
            end else begin
               m_t++;
               if (m_t == ST) begin m_phase = P_RUN; m_retry = 0; m_t = 0; end
            end
         end
         P_RUN: begin
            if (!lk) begin
`ifdef PLL_SEQ_LOSS_COUNT_EN
               if (m_loss < 255) m_loss++;
`endif
               m_phase = P_RST; m_t = 0;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic check_all();
      check("pll_rst",       32'(pll_rst),       32'(m_phase == P_RST || m_phase == P_FAULT));
      check("core_reset",    32'(core_reset),    32'(m_phase != P_RUN));
      check("fault",         32'(fault),         32'(m_phase == P_FAULT));
      check("retry_cnt",     32'(retry_cnt),     32'(m_retry));
      check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
   endtask

   task automatic step(input bit pl, input bit sr);
      pll_locked = pl;
      soft_reset = sr;
      @(posedge refclk);
      cyc++;
      if (rst_n) model_edge(pl, sr);
      #1;
      check_all();
   endtask

   // drive lock (with occasional random glitches) until core_reset releases
   task automatic wait_run(input int budget, input int glitch_div);
      int used;
      used = 0;
      while (used < budget && core_reset !== 1'b0) begin
         used++;
         step((glitch_div > 0) ? ($urandom_range(glitch_div - 1) != 0) : 1'b1, 1'b0);
      end
      check("reach_run", 32'(core_reset), 32'(0));
   endtask

   initial begin
      int k, rst_fall, core_fall, n, off, rises, lb, cnt_hi;
      bit prev;

      rst_n      = 1'b0;
      pll_locked = 1'b0;
      soft_reset = 1'b0;
      model_reset();
      repeat (3) @(posedge refclk);
      #1;
      check("reset_pll_rst",    32'(pll_rst),       32'(1));
      check("reset_core_reset", 32'(core_reset),    32'(1));
      check("reset_fault",      32'(fault),         32'(0));
      check("reset_retry",      32'(retry_cnt),     32'(0));
      check("reset_loss",       32'(lock_loss_cnt), 32'(0));
      rst_n = 1'b1;

      // bring-up: lock rises at cycle 100
      k = 0; rst_fall = -1; core_fall = -1;
      while (k < 600 && core_fall < 0) begin
         k++;
         step(k >= 100, 1'b0);
         if (rst_fall < 0 && pll_rst === 1'b0) rst_fall = k;
         if (core_reset === 1'b0) core_fall = k;
      end
      check("bringup_pulse_len", 32'(rst_fall), 32'(RP));
      check("bringup_core_fall_window",
            32'(core_fall >= 100 + 2 + ST - 1 && core_fall <= 100 + 2 + ST + 1), 32'(1));
      check("bringup_retry", 32'(retry_cnt), 32'(0));

      // lock drops for 3 cycles in RUN
      lb = m_loss; n = -1; cnt_hi = 0;
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b0);
         if (n < 0 && core_reset === 1'b1) n = i;
         if (pll_rst === 1'b1) cnt_hi++;
      end
      check("drop_core_reset_within3", 32'(n >= 1 && n <= 3), 32'(1));
      k = 0;
      while (k < 500 && core_reset !== 1'b0) begin
         k++;
         step(1'b1, 1'b0);
         if (pll_rst === 1'b1) cnt_hi++;
      end
      check("drop_pulse_len", 32'(cnt_hi), 32'(RP));
      check("drop_rerun", 32'(core_reset), 32'(0));
`ifdef PLL_SEQ_LOSS_COUNT_EN
      check("drop_loss_inc", 32'(lock_loss_cnt), 32'(lb + 1));
`else
      check("drop_loss_inc", 32'(lock_loss_cnt), 32'(0));
`endif

      // soft reset in RUN with lock steady
      lb = m_loss;
      step(1'b1, 1'b1);
      check("sr_run_pll_rst", 32'(pll_rst), 32'(1));
      check("sr_run_retry", 32'(retry_cnt), 32'(0));
      check("sr_run_loss", 32'(lock_loss_cnt), 32'(lb));

      // one-cycle lock glitch halfway through the stable window
      n = 0;
      while (n < 2000 && !(m_phase == P_STAB && m_t == ST / 2)) begin
         n++;
         step(1'b1, 1'b0);
      end
      check("stable_mid_budget", 32'(n < 2000), 32'(1));
      step(1'b0, 1'b0);
      off = 1;
      while (off < 500 && core_reset !== 1'b0) begin
         off++;
         step(1'b1, 1'b0);
      end
      check("glitch_rewindow", 32'(off), 32'(ST + 4));

      // soft reset coinciding with the synchronized lock drop
      lb = m_loss;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("sr_drop_pll_rst", 32'(pll_rst), 32'(1));
      check("sr_drop_retry", 32'(retry_cnt), 32'(0));
      check("sr_drop_no_double", 32'(lock_loss_cnt), 32'(lb));
      wait_run(1000, 0);

      // rst_n asserted mid-sequence restarts with a full pulse
      n = 0;
      while (n < 1000 && m_phase != P_STAB) begin
         n++;
         step(1'b1, (n == 1));
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) step(1'b1, 1'b0);
      rst_n = 1'b1;
      k = 0; rst_fall = -1;
      while (k < 100 && rst_fall < 0) begin
         k++;
         step(1'b1, 1'b0);
         if (pll_rst === 1'b0) rst_fall = k;
      end
      check("midreset_pulse_len", 32'(rst_fall), 32'(RP));

      // lock never arrives: retries exhaust into FAULT
      step(1'b0, 1'b1);
      prev = pll_rst; rises = 0; k = 0;
      while (k < 8 * (TO + RP) + 50 && fault !== 1'b1) begin
         k++;
         step(1'b0, 1'b0);
         if (pll_rst === 1'b1 && !prev) rises++;
         prev = pll_rst;
      end
      check("fault_set", 32'(fault), 32'(1));
      check("fault_retry", 32'(retry_cnt), 32'(MR));
      check("fault_timeouts", 32'(rises), 32'(MR));
      check("fault_pll_rst", 32'(pll_rst), 32'(1));
      repeat (20) step($urandom_range(1), 1'b0);
      check("fault_sticky", 32'(fault), 32'(1));
      step(1'b1, 1'b1);
      check("sr_fault_exit", 32'(fault), 32'(0));
      check("sr_fault_retry", 32'(retry_cnt), 32'(0));

      // 300 randomized lock losses
      for (int i = 0; i < 300; i++) begin
         wait_run(3000, 200);
         repeat ($urandom_range(4)) step(1'b1, ($urandom_range(31) == 0));
         wait_run(3000, 0);
         repeat ($urandom_range(3, 1)) step(1'b0, 1'b0);
      end
      wait_run(3000, 0);
`ifdef PLL_SEQ_LOSS_COUNT_EN
      check("loss_saturated", 32'(lock_loss_cnt), 32'(255));
`else
      check("loss_tied_zero", 32'(lock_loss_cnt), 32'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: number of refclk cycles pll_rst is held per reset attempt.
REQ-002 Parameter LOCK_TIMEOUT_CYC, default 50000: cycles in WAIT_LOCK before the attempt fails.
REQ-003 Parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-locked cycles required before release.
REQ-004 Parameter MAX_RETRY, default 7: failed attempts allowed before entering FAULT.
REQ-005 refclk  in  1  single clock, 50 MHz PLL reference clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 pll_locked  in  1  PLL locked output; asynchronous to refclk.
REQ-008 soft_reset  in  1  synchronous request; forces a new PLL reset sequence.
REQ-009 pll_rst  out  1  active-high reset driven to the PLL rst input.
REQ-010 core_reset  out  1  active-high reset for logic on the PLL output clocks.
REQ-011 fault  out  1  high while in FAULT.
REQ-012 retry_cnt  out  3  failed attempts in the current sequence.
REQ-013 lock_loss_cnt  out  8  saturating count of lock losses seen in RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value lk.
REQ-015 States SHALL be PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT.
REQ-016 PLL_RST: pll_rst=1 and core_reset=1 for exactly RST_PULSE_CYC cycles; then go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lk=1 goes to STABLE with the stable counter cleared; timeout after LOCK_TIMEOUT_CYC cycles increments retry_cnt.
REQ-018 On timeout, go to PLL_RST when retry_cnt < MAX_RETRY, else go to FAULT.
REQ-019 STABLE: lk=0 returns to WAIT_LOCK with the timeout counter cleared; LOCK_STABLE_CYC consecutive lk=1 cycles go to RUN.
REQ-020 RUN: core_reset=0 from the first RUN cycle; retry_cnt cleared on entry.
REQ-021 RUN: lk=0 increments lock_loss_cnt (saturating at 255) and goes to PLL_RST.
REQ-022 FAULT: pll_rst=1, core_reset=1, fault=1; exits only through soft_reset or rst_n.
REQ-023 soft_reset=1 in any state goes to PLL_RST next cycle, restarts the pulse counter and clears retry_cnt; it takes priority over every other transition in the same cycle.
REQ-024 core_reset SHALL be 1 in every state except RUN, and SHALL be a registered output.
REQ-025 Counter widths SHALL be $clog2(parameter+1); no counter wraps; each clears on state entry.

Reset
REQ-026 While rst_n=0: state=PLL_RST, pll_rst=1, core_reset=1, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
REQ-027 Deassertion of rst_n mid-sequence SHALL restart from a full RST_PULSE_CYC pulse.

Configuration
REQ-028 Macro PLL_SEQ_LOSS_COUNT_EN: when defined, lock_loss_cnt behaves per REQ-021; when undefined, lock_loss_cnt is tied to 0 and its counter is not synthesized. All other behaviour is unchanged.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-030 The synchronizer SHALL be sub-module pll_lock_sync (2-flop, async active-low reset to 0).

Verification
REQ-031 rst_n release, pll_locked rises at cycle 100 and holds: pll_rst high for 16 cycles; core_reset falls at cycle 100 + 2 + 1024 (±1); retry_cnt=0.
REQ-032 pll_locked held 0: 7 timeouts of 50000 cycles, each followed by a 16-cycle pll_rst pulse; fault=1 and retry_cnt=7 after the 7th timeout.
REQ-033 In RUN, pll_locked drops for 3 cycles: core_reset asserts within 3 cycles, pll_rst pulses 16 cycles, lock_loss_cnt increments by 1, then RUN is re-entered.
REQ-034 In STABLE, a 1-cycle lk glitch low at stable count 500 returns to WAIT_LOCK; a full 1024-cycle window is required again.
REQ-035 soft_reset asserted in FAULT and in RUN, including the same cycle as an lk drop: next state PLL_RST, retry_cnt=0, no double lock_loss_cnt increment.
REQ-036 Build without PLL_SEQ_LOSS_COUNT_EN, 300 lock losses: lock_loss_cnt stays 0. Build with it: lock_loss_cnt saturates at 255.
